// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: per-register countdown scoreboard for long-latency producers.
// Stalls decode on RAW against a pending load/multiply result and on WAW where the
// instruction in decode would complete before an older write to the same register.
// Optional feature macro: HAZARD_STATS_EN adds the o_stall_count statistics port.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR = 5,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MULT_LAT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_dec_valid,
    input  logic [REG_ADDR-1:0]      i_src1,
    input  logic [REG_ADDR-1:0]      i_src2,
    input  logic                     i_use_src1,
    input  logic                     i_use_src2,
    input  logic [REG_ADDR-1:0]      i_dest,
    input  logic                     i_regwrite,
    input  logic                     i_is_load,
    input  logic                     i_is_mult,
    input  logic                     i_flush,
    output logic                     o_stall,
    output logic                     o_dec_we,
    output logic                     o_bubble,
    output logic [(2**REG_ADDR)-1:0] o_busy_mask
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]              o_stall_count
`endif
);

    localparam int unsigned NREG    = 2 ** REG_ADDR;
    localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

    // Latencies must fit the counters, otherwise they would wrap and release early.
    if (LOAD_LAT > CNT_MAX) begin : g_bad_load_lat
        $error("hazard_scoreboard: LOAD_LAT exceeds 2**CNT_W-1");
    end
    if (MULT_LAT > CNT_MAX) begin : g_bad_mult_lat
        $error("hazard_scoreboard: MULT_LAT exceeds 2**CNT_W-1");
    end

    logic [CNT_W-1:0] r_cnt   [NREG];
    logic [CNT_W-1:0] w_cnt_d [NREG];
    logic [NREG-1:0]  r_busy;
    logic [NREG-1:0]  w_busy_d;
    logic [CNT_W-1:0] w_lat;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_stall;
    logic             w_issue;

    // Result latency of the instruction in decode; multiply wins over load.
    always_comb begin
        w_lat = '0;
        if (i_is_mult) begin
            w_lat = CNT_W'(MULT_LAT);
        end else if (i_is_load) begin
            w_lat = CNT_W'(LOAD_LAT);
        end
    end

    // Hazard detection; reset forces all interlock outputs inactive.
    always_comb begin
        w_raw1  = i_use_src1 & (i_src1 != '0) & (r_cnt[i_src1] != '0);
        w_raw2  = i_use_src2 & (i_src2 != '0) & (r_cnt[i_src2] != '0);
        w_waw   = i_regwrite & (i_dest != '0) & (r_cnt[i_dest] > w_lat);
        w_stall = i_reset & i_dec_valid & ~i_flush & (w_raw1 | w_raw2 | w_waw);
        w_issue = i_dec_valid & ~i_flush & ~w_stall;
    end

    // Outputs: a flush still bubbles ID/EX but keeps dec_we high for the redirect.
    always_comb begin
        o_stall     = w_stall;
        o_dec_we    = ~w_stall;
        o_bubble    = i_reset & (w_stall | i_flush);
        o_busy_mask = r_busy;
    end

    // Next-state counters: an issuing write reloads its register, others count down.
    always_comb begin
        w_busy_d = '0;
        for (int r = 0; r < NREG; r++) begin
            w_cnt_d[r] = '0;
            if (r != 0) begin
                if (w_issue && i_regwrite && (i_dest == REG_ADDR'(r)) && (w_lat != '0)) begin
                    w_cnt_d[r] = w_lat;
                end else if (r_cnt[r] != '0) begin
                    w_cnt_d[r] = r_cnt[r] - CNT_W'(1);
                end
            end
            w_busy_d[r] = (w_cnt_d[r] != '0);
        end
    end

    // Scoreboard state and busy mask, both taken from the next-state counters.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= w_cnt_d[r];
            end
            r_busy <= w_busy_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;

    // Stall-cycle statistics; free-running, wraps at 2**32.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_count <= '0;
        end else if (w_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expected interlock outputs are queued as
// each decode cycle is driven and popped/compared at the following falling edge.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       dv;
        logic [4:0] s1;
        logic       u1;
        logic [4:0] s2;
        logic       u2;
        logic [4:0] d;
        logic       rw;
        logic       ld;
        logic       ml;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic [31:0] busy;
    } exp_t;

    logic        i_clk;
    logic        i_reset;
    logic        i_dec_valid;
    logic [4:0]  i_src1;
    logic [4:0]  i_src2;
    logic        i_use_src1;
    logic        i_use_src2;
    logic [4:0]  i_dest;
    logic        i_regwrite;
    logic        i_is_load;
    logic        i_is_mult;
    logic        i_flush;
    logic        o_stall;
    logic        o_dec_we;
    logic        o_bubble;
    logic [31:0] o_busy_mask;
`ifdef HAZARD_STATS_EN
    logic [31:0] o_stall_count;
`endif

    exp_t q_exp[$];
    int   n_pass  = 0;
    int   n_total = 0;

    hazard_scoreboard u_dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_dec_valid (i_dec_valid),
        .i_src1      (i_src1),
        .i_src2      (i_src2),
        .i_use_src1  (i_use_src1),
        .i_use_src2  (i_use_src2),
        .i_dest      (i_dest),
        .i_regwrite  (i_regwrite),
        .i_is_load   (i_is_load),
        .i_is_mult   (i_is_mult),
        .i_flush     (i_flush),
        .o_stall     (o_stall),
        .o_dec_we    (o_dec_we),
        .o_bubble    (o_bubble),
        .o_busy_mask (o_busy_mask)
`ifdef HAZARD_STATS_EN
        ,
        .o_stall_count (o_stall_count)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic stim_t mk(input logic dv, input logic [4:0] s1, input logic u1,
                                 input logic [4:0] s2, input logic u2, input logic [4:0] d,
                                 input logic rw, input logic ld, input logic ml, input logic fl);
        stim_t s;
        s.dv = dv; s.s1 = s1; s.u1 = u1; s.s2 = s2; s.u2 = u2;
        s.d = d; s.rw = rw; s.ld = ld; s.ml = ml; s.fl = fl;
        return s;
    endfunction

    function automatic exp_t ev(input logic stall, input logic bubble, input logic [31:0] busy);
        exp_t e;
        e.stall = stall; e.bubble = bubble; e.busy = busy;
        return e;
    endfunction

    function automatic logic [31:0] bm(input int r);
        logic [31:0] one;
        one = 32'd1;
        return one << r;
    endfunction

    task automatic drive(input stim_t s);
        i_dec_valid = s.dv; i_src1 = s.s1; i_use_src1 = s.u1; i_src2 = s.s2;
        i_use_src2 = s.u2; i_dest = s.d; i_regwrite = s.rw; i_is_load = s.ld;
        i_is_mult = s.ml; i_flush = s.fl;
    endtask

    // One decode cycle: drive after the rising edge, queue expectation, move to falling edge.
    task automatic step(input stim_t s, input exp_t e);
        @(posedge i_clk);
        #1;
        drive(s);
        q_exp.push_back(e);
        @(negedge i_clk);
    endtask

    task automatic test_reset;
        exp_t e;
        i_reset = 1'b0;
        drive(mk(1, 3, 1, 3, 1, 3, 1, 0, 1, 1));
        q_exp.push_back(ev(0, 0, 32'd0));
        #12;
        e = q_exp.pop_front();
        n_total += 4;
        if (o_stall !== e.stall) $display("FAIL reset stall: got %b want %b", o_stall, e.stall);
        else n_pass++;
        if (o_bubble !== e.bubble) $display("FAIL reset bubble: got %b want %b", o_bubble, e.bubble);
        else n_pass++;
        if (o_dec_we !== 1'b1) $display("FAIL reset dec_we: got %b want 1", o_dec_we);
        else n_pass++;
        if (o_busy_mask !== e.busy) $display("FAIL reset busy: got %h want %h", o_busy_mask, e.busy);
        else n_pass++;
`ifdef HAZARD_STATS_EN
        n_total++;
        if (o_stall_count !== 32'd0) $display("FAIL reset stall_count: got %0d want 0", o_stall_count);
        else n_pass++;
`endif
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    task automatic test_raw_load;
        stim_t st[4];
        exp_t  ex[4];
        exp_t  e;
        st[0] = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); ex[0] = ev(0, 0, 32'd0);
        st[1] = mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0); ex[1] = ev(1, 1, bm(3));
        st[2] = st[1];                            ex[2] = ev(0, 0, 32'd0);
        st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[3] = ev(0, 0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(st[i], ex[i]);
            e = q_exp.pop_front();
            n_total += 4;
            if (o_stall !== e.stall) $display("FAIL raw_load[%0d] stall: got %b want %b", i, o_stall, e.stall);
            else n_pass++;
            if (o_bubble !== e.bubble) $display("FAIL raw_load[%0d] bubble: got %b want %b", i, o_bubble, e.bubble);
            else n_pass++;
            if (o_dec_we !== ~e.stall) $display("FAIL raw_load[%0d] dec_we: got %b want %b", i, o_dec_we, ~e.stall);
            else n_pass++;
            if (o_busy_mask !== e.busy) $display("FAIL raw_load[%0d] busy: got %h want %h", i, o_busy_mask, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_raw_mult;
        stim_t st[7];
        exp_t  ex[7];
        exp_t  e;
        st[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 0); ex[0] = ev(0, 0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            st[i] = mk(1, 0, 0, 5, 1, 6, 1, 0, 0, 0); ex[i] = ev(1, 1, bm(5));
        end
        st[5] = st[1];                            ex[5] = ev(0, 0, 32'd0);
        st[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[6] = ev(0, 0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(st[i], ex[i]);
            e = q_exp.pop_front();
            n_total += 4;
            if (o_stall !== e.stall) $display("FAIL raw_mult[%0d] stall: got %b want %b", i, o_stall, e.stall);
            else n_pass++;
            if (o_bubble !== e.bubble) $display("FAIL raw_mult[%0d] bubble: got %b want %b", i, o_bubble, e.bubble);
            else n_pass++;
            if (o_dec_we !== ~e.stall) $display("FAIL raw_mult[%0d] dec_we: got %b want %b", i, o_dec_we, ~e.stall);
            else n_pass++;
            if (o_busy_mask !== e.busy) $display("FAIL raw_mult[%0d] busy: got %h want %h", i, o_busy_mask, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_waw;
        stim_t st[13];
        exp_t  ex[13];
        exp_t  e;
        stim_t idle;
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        st[0] = mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0); ex[0] = ev(0, 0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            st[i] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); ex[i] = ev(1, 1, bm(7));
        end
        st[5]  = st[1];                            ex[5]  = ev(0, 0, 32'd0);
        st[6]  = idle;                             ex[6]  = ev(0, 0, 32'd0);
        st[7]  = st[0];                            ex[7]  = ev(0, 0, 32'd0);
        st[8]  = mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0); ex[8]  = ev(0, 0, bm(7));
        st[9]  = idle;                             ex[9]  = ev(0, 0, bm(7));
        st[10] = idle;                             ex[10] = ev(0, 0, bm(7));
        st[11] = idle;                             ex[11] = ev(0, 0, bm(7));
        st[12] = idle;                             ex[12] = ev(0, 0, 32'd0);
        for (int i = 0; i < 13; i++) begin
            step(st[i], ex[i]);
            e = q_exp.pop_front();
            n_total += 4;
            if (o_stall !== e.stall) $display("FAIL waw[%0d] stall: got %b want %b", i, o_stall, e.stall);
            else n_pass++;
            if (o_bubble !== e.bubble) $display("FAIL waw[%0d] bubble: got %b want %b", i, o_bubble, e.bubble);
            else n_pass++;
            if (o_dec_we !== ~e.stall) $display("FAIL waw[%0d] dec_we: got %b want %b", i, o_dec_we, ~e.stall);
            else n_pass++;
            if (o_busy_mask !== e.busy) $display("FAIL waw[%0d] busy: got %h want %h", i, o_busy_mask, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_reg0;
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e;
        st[0] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); ex[0] = ev(0, 0, 32'd0);
        st[1] = mk(1, 0, 1, 0, 1, 0, 1, 0, 1, 0); ex[1] = ev(0, 0, 32'd0);
        st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[2] = ev(0, 0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(st[i], ex[i]);
            e = q_exp.pop_front();
            n_total += 3;
            if (o_stall !== e.stall) $display("FAIL reg0[%0d] stall: got %b want %b", i, o_stall, e.stall);
            else n_pass++;
            if (o_bubble !== e.bubble) $display("FAIL reg0[%0d] bubble: got %b want %b", i, o_bubble, e.bubble);
            else n_pass++;
            if (o_busy_mask !== e.busy) $display("FAIL reg0[%0d] busy: got %h want %h", i, o_busy_mask, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_flush;
        stim_t st[7];
        exp_t  ex[7];
        exp_t  e;
        st[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 0);  ex[0] = ev(0, 0, 32'd0);
        // Flushed multiply to r9 reading r5: bubble only, no scoreboard update.
        st[1] = mk(1, 5, 1, 0, 0, 9, 1, 0, 1, 1);  ex[1] = ev(0, 1, bm(5));
        st[2] = mk(1, 5, 1, 0, 0, 10, 1, 0, 0, 0); ex[2] = ev(1, 1, bm(5));
        st[3] = st[2];                             ex[3] = ev(1, 1, bm(5));
        st[4] = st[2];                             ex[4] = ev(1, 1, bm(5));
        st[5] = st[2];                             ex[5] = ev(0, 0, 32'd0);
        st[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ex[6] = ev(0, 0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(st[i], ex[i]);
            e = q_exp.pop_front();
            n_total += 4;
            if (o_stall !== e.stall) $display("FAIL flush[%0d] stall: got %b want %b", i, o_stall, e.stall);
            else n_pass++;
            if (o_bubble !== e.bubble) $display("FAIL flush[%0d] bubble: got %b want %b", i, o_bubble, e.bubble);
            else n_pass++;
            if (o_dec_we !== ~e.stall) $display("FAIL flush[%0d] dec_we: got %b want %b", i, o_dec_we, ~e.stall);
            else n_pass++;
            if (o_busy_mask !== e.busy) $display("FAIL flush[%0d] busy: got %h want %h", i, o_busy_mask, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        stim_t st[8];
        exp_t  ex[8];
        exp_t  e;
        st[0] = mk(1, 0, 0, 0, 0, 12, 1, 0, 1, 0); ex[0] = ev(0, 0, 32'd0);
        // Load+mult to the same register: multiply latency, no WAW (4 > 4 is false), reloads.
        st[1] = mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0); ex[1] = ev(0, 0, bm(12));
        for (int i = 2; i <= 5; i++) begin
            st[i] = mk(1, 12, 1, 12, 1, 13, 1, 0, 0, 0); ex[i] = ev(1, 1, bm(12));
        end
        st[6] = st[2];                             ex[6] = ev(0, 0, 32'd0);
        st[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ex[7] = ev(0, 0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(st[i], ex[i]);
            e = q_exp.pop_front();
            n_total += 3;
            if (o_stall !== e.stall) $display("FAIL back_to_back[%0d] stall: got %b want %b", i, o_stall, e.stall);
            else n_pass++;
            if (o_bubble !== e.bubble) $display("FAIL back_to_back[%0d] bubble: got %b want %b", i, o_bubble, e.bubble);
            else n_pass++;
            if (o_busy_mask !== e.busy) $display("FAIL back_to_back[%0d] busy: got %h want %h", i, o_busy_mask, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        stim_t st[9];
        exp_t  ex[9];
        exp_t  e;
        stim_t rd;
        rd    = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        st[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 0); ex[0] = ev(0, 0, 32'd0);
        st[1] = rd;                               ex[1] = ev(1, 1, bm(5));
        st[2] = rd;                               ex[2] = ev(1, 1, bm(5));
        for (int i = 0; i < 3; i++) begin
            step(st[i], ex[i]);
            e = q_exp.pop_front();
            n_total += 2;
            if (o_stall !== e.stall) $display("FAIL reset_mid[%0d] stall: got %b want %b", i, o_stall, e.stall);
            else n_pass++;
            if (o_busy_mask !== e.busy) $display("FAIL reset_mid[%0d] busy: got %h want %h", i, o_busy_mask, e.busy);
            else n_pass++;
        end
        #1 i_reset = 1'b0;
        #1;
        n_total += 4;
        if (o_stall !== 1'b0) $display("FAIL reset_mid async stall: got %b want 0", o_stall);
        else n_pass++;
        if (o_bubble !== 1'b0) $display("FAIL reset_mid async bubble: got %b want 0", o_bubble);
        else n_pass++;
        if (o_dec_we !== 1'b1) $display("FAIL reset_mid async dec_we: got %b want 1", o_dec_we);
        else n_pass++;
        if (o_busy_mask !== 32'd0) $display("FAIL reset_mid async busy: got %h want 0", o_busy_mask);
        else n_pass++;
`ifdef HAZARD_STATS_EN
        n_total++;
        if (o_stall_count !== 32'd0) $display("FAIL reset_mid stall_count clear: got %0d want 0", o_stall_count);
        else n_pass++;
`endif
        #1 i_reset = 1'b1;
        #1;
        n_total++;
        if (o_stall !== 1'b0) $display("FAIL reset_mid release stall: got %b want 0", o_stall);
        else n_pass++;
        // After release: same reader never stalls, then a late reader stalls 3 cycles.
        st[0] = rd;                               ex[0] = ev(0, 0, 32'd0);
        st[1] = mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 0); ex[1] = ev(0, 0, 32'd0);
        st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[2] = ev(0, 0, bm(5));
        st[3] = rd;                               ex[3] = ev(1, 1, bm(5));
        st[4] = rd;                               ex[4] = ev(1, 1, bm(5));
        st[5] = rd;                               ex[5] = ev(1, 1, bm(5));
        st[6] = rd;                               ex[6] = ev(0, 0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(st[i], ex[i]);
            e = q_exp.pop_front();
            n_total += 3;
            if (o_stall !== e.stall) $display("FAIL reset_after[%0d] stall: got %b want %b", i, o_stall, e.stall);
            else n_pass++;
            if (o_bubble !== e.bubble) $display("FAIL reset_after[%0d] bubble: got %b want %b", i, o_bubble, e.bubble);
            else n_pass++;
            if (o_busy_mask !== e.busy) $display("FAIL reset_after[%0d] busy: got %h want %h", i, o_busy_mask, e.busy);
            else n_pass++;
        end
`ifdef HAZARD_STATS_EN
        n_total++;
        if (o_stall_count !== 32'd3) $display("FAIL reset_after stall_count: got %0d want 3", o_stall_count);
        else n_pass++;
`endif
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ev(0, 0, 32'd0));
        e = q_exp.pop_front();
        n_total++;
        if (o_stall !== e.stall) $display("FAIL reset_after idle stall: got %b want %b", o_stall, e.stall);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_raw_load();
        test_raw_mult();
        test_waw();
        test_reg0();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Interlock controller for the decode stage.
- Tracks in-flight register writes from long-latency producers (loads, multiplies) with a per-register countdown scoreboard.
- Stalls decode and injects a bubble into ID/EX when the instruction in decode would read a result not yet forwardable, or would complete out of order with an older write to the same register (WAW).
- Sits beside the decode stage: drives its write enable and the stall input of its control generator.

Parameters:
- REG_ADDR, 5, register address width; the register file holds 2**REG_ADDR registers.
- CNT_W, 3, scoreboard counter width.
- LOAD_LAT, 1, stall cycles a dependent instruction needs after a load issues.
- MULT_LAT, 4, stall cycles a dependent instruction needs after a multiply issues.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode holds a real instruction.
- src1  in  REG_ADDR  first source register address.
- src2  in  REG_ADDR  second source register address.
- use_src1  in  1  instruction reads src1.
- use_src2  in  1  instruction reads src2.
- dest  in  REG_ADDR  destination register address.
- regwrite  in  1  instruction writes dest.
- is_load  in  1  instruction is a load.
- is_mult  in  1  instruction is a multiply.
- flush  in  1  kill the instruction in decode (taken branch or jump).
- stall  out  1  hold fetch and decode, combinational.
- dec_we  out  1  decode boundary write enable, equal to ~stall.
- bubble  out  1  zero the ID/EX control signals this cycle, combinational.
- busy_mask  out  2**REG_ADDR  bit r set while cnt[r] != 0, registered.
- stall_count  out  32  total stall cycles, present only with HAZARD_STATS_EN.

Behaviour:
- State: cnt[r], one CNT_W-bit counter per register. Register 0 is never tracked; cnt[0] is held at 0.
- Reset (reset low, asynchronous): every cnt = 0; busy_mask = 0; stall_count = 0. While reset is asserted, stall = 0, bubble = 0, dec_we = 1.
- RAW hazard:
  - raw1 = use_src1 & (src1 != 0) & (cnt[src1] != 0)
  - raw2 = use_src2 & (src2 != 0) & (cnt[src2] != 0)
- Latency of the instruction in decode:
  - lat = MULT_LAT if is_mult
  - else LOAD_LAT if is_load
  - else 0 (ALU results are forwarded; never tracked)
  - is_mult takes priority when is_mult and is_load are both set.
- WAW hazard: waw = regwrite & (dest != 0) & (cnt[dest] > lat).
- stall = dec_valid & ~flush & (raw1 | raw2 | waw).
- bubble = stall | flush.
- dec_we = ~stall. During flush dec_we stays 1 so the fetch redirect is accepted.
- Issue: issue = dec_valid & ~flush & ~stall.
- Per-cycle update, every register r != 0:
  - if issue & regwrite & (dest == r) & (lat != 0): cnt[r] <= lat. Issue wins over decrement on the same register.
  - else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - else: hold 0.
- Timing:
  - Producer issues in cycle T with latency L; a consumer in decode at T+1 stalls for exactly L cycles and issues at T+1+L.
  - A consumer arriving later stalls for the remaining count only.
- Counters never wrap. LOAD_LAT and MULT_LAT must be at most 2**CNT_W-1; an initial check reports an error otherwise.
- Stalled instructions do not update the scoreboard. Flushed instructions never update it.
- busy_mask is registered from the next-state counters, so it matches cnt after each edge.
- A reset asserted mid-sequence clears all counters immediately; the first instruction after reset release never stalls.

Optional Feature:
- HAZARD_STATS_EN defined: the stall_count port exists. It increments by 1 on every clock edge where stall = 1, wraps at 2**32, and clears on reset.
- HAZARD_STATS_EN not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Load r3 (dest=3, is_load) issues at T; at T+1 an add reads r3 via src1 -> stall=1 and bubble=1 for 1 cycle; the add issues at T+2 with dec_we=1.
- Mul r5 issues (MULT_LAT=4); the next instruction reads r5 via src2 -> stall held 4 cycles; busy_mask[5]=1 for those 4 cycles, then 0.
- Mul r7 issues; the next instruction is an ALU write to r7 (lat 0) with no source dependence -> WAW stall 4 cycles; the same sequence with an ALU write to r8 -> no stall.
- Load r0 followed by a read of r0 -> no stall; busy_mask stays 0.
- Mul r5 issues; the next instruction reads r5 with flush=1 -> stall=0, bubble=1, scoreboard untouched; cnt[5] keeps decrementing.
- Reset pulsed low during a 4-cycle mul stall -> stall drops asynchronously and busy_mask=0; with HAZARD_STATS_EN, stall_count=0, and after 3 later stall cycles it equals 3.
